// File: rtl/nofx2_pkg.sv
// nofx2_pkg: definitions shared by the frame packer.
//   - NOFX2_HDR_W    : width of one ATRI frame word (16 bits)
//   - nofx2_state_e  : packer FSM states
//   - ceil_div()     : integer ceiling division, used for the output-word count of a frame
package nofx2_pkg;

  localparam int unsigned NOFX2_HDR_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LENGTH,
    ST_DATA,
    ST_DROP
  } nofx2_state_e;

  function automatic logic [16:0] ceil_div(input logic [16:0] num, input int unsigned den);
    logic [31:0] t;
    t = 32'(num) + den - 1;
    return 17'(t / den);
  endfunction

endpackage

// File: rtl/nofx2_frame_packer_if.sv
// nofx2_frame_packer_if: frame-input, flush, read and status signals of the packer.
//   master : frame source / host side (drives dat_i, wr_i, flush_i, rd_i)
//   slave  : the packer (drives dat_o, empty_o, full_o, count_o, drop_cnt_o, frame_done_o)
interface nofx2_frame_packer_if #(
  parameter int unsigned OUT_W = 32
);
  logic [15:0]      dat_i;
  logic             wr_i;
  logic             flush_i;
  logic             rd_i;
  logic [OUT_W-1:0] dat_o;
  logic             empty_o;
  logic             full_o;
  logic [15:0]      count_o;
  logic [15:0]      drop_cnt_o;
  logic             frame_done_o;

  modport master (
    output dat_i, wr_i, flush_i, rd_i,
    input  dat_o, empty_o, full_o, count_o, drop_cnt_o, frame_done_o
  );

  modport slave (
    input  dat_i, wr_i, flush_i, rd_i,
    output dat_o, empty_o, full_o, count_o, drop_cnt_o, frame_done_o
  );
endinterface

// File: rtl/nofx2_sync_fifo.sv
// nofx2_sync_fifo: single-clock FIFO with registered (non-FWFT) read data.
//   clk, rst_n_i : clock, async active-low reset
//   flush_i      : synchronous clear of pointers and occupancy (wins over wr/rd)
//   wr_i, wdat_i : write strobe / data (ignored when full)
//   rd_i, rdat_o : read strobe / data, rdat_o updates the cycle after an accepted read
//   used_o       : number of stored words
//   full_o, empty_o
module nofx2_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 32768
) (
  input  logic                     clk,
  input  logic                     rst_n_i,
  input  logic                     flush_i,
  input  logic                     wr_i,
  input  logic [WIDTH-1:0]         wdat_i,
  input  logic                     rd_i,
  output logic [WIDTH-1:0]         rdat_o,
  output logic [$clog2(DEPTH):0]   used_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_used;
  logic [WIDTH-1:0] r_rdat;
  logic             w_do_wr;
  logic             w_do_rd;

  assign full_o  = (r_used == (AW+1)'(DEPTH));
  assign empty_o = (r_used == '0);
  assign w_do_wr = wr_i && !flush_i && !full_o;
  assign w_do_rd = rd_i && !flush_i && !empty_o;
  assign rdat_o  = r_rdat;
  assign used_o  = r_used;

  // Storage kept free of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wptr] <= wdat_i;
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_used <= '0;
      r_rdat <= '0;
    end else if (flush_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_used <= '0;
    end else begin
      if (w_do_wr) r_wptr <= r_wptr + 1'b1;
      if (w_do_rd) begin
        r_rdat <= r_mem[r_rptr];
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_do_wr, w_do_rd})
        2'b10:   r_used <= r_used + 1'b1;
        2'b01:   r_used <= r_used - 1'b1;
        default: r_used <= r_used;
      endcase
    end
  end
endmodule

// File: rtl/nofx2_frame_packer.sv
// nofx2_frame_packer: packs 16-bit ATRI frames (header, length, length data words)
// into OUT_W-bit words with frame-granular admission into an internal FIFO.
//   clk, rst_n_i : clock, async active-low reset
//   bus (slave)  : dat_i/wr_i frame input, flush_i, rd_i/dat_o read port,
//                  empty_o, full_o, count_o (16-bit words stored), drop_cnt_o,
//                  frame_done_o (pulse after a frame's last output word is written)
module nofx2_frame_packer
  import nofx2_pkg::*;
#(
  parameter int unsigned RATIO     = 2,
  parameter int unsigned OUT_W     = 16 * RATIO,
  parameter int unsigned DEPTH     = 32768,
  parameter logic [15:0] PAD_VALUE = 16'h0000
) (
  input logic                 clk,
  input logic                 rst_n_i,
  nofx2_frame_packer_if.slave bus
);
  localparam int unsigned LW = $clog2(RATIO);
  localparam int unsigned AW = $clog2(DEPTH);

  nofx2_state_e           r_state;
  nofx2_state_e           w_state_nxt;
  logic [NOFX2_HDR_W-1:0] r_lanes [RATIO];
  logic [LW-1:0]          r_lane;
  logic [15:0]            r_remaining;
  logic [15:0]            r_drop_cnt;
  logic                   r_frame_done;

  logic [AW:0]      w_used;
  logic [16:0]      w_need;
  logic [31:0]      w_free;
  logic             w_fits;
  logic             w_push;
  logic             w_last;
  logic             w_store;
  logic             w_drop_inc;
  logic [LW-1:0]    w_lane_nxt;
  logic [15:0]      w_rem_nxt;
  logic [OUT_W-1:0] w_word;
  logic [31:0]      w_cnt_full;

  // Admission: free space comes from the registered occupancy; a same-cycle read
  // only adds space, so this is conservative.
  assign w_need = ceil_div({1'b0, bus.dat_i} + 17'd2, RATIO);
  assign w_free = 32'(DEPTH) - 32'(w_used);
  assign w_fits = (32'(w_need) <= w_free);

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.flush_i) begin
      w_state_nxt = ST_IDLE;
    end else if (bus.wr_i) begin
      case (r_state)
        ST_IDLE:   w_state_nxt = ST_LENGTH;
        ST_LENGTH: w_state_nxt = (bus.dat_i == '0) ? ST_IDLE : (w_fits ? ST_DATA : ST_DROP);
        ST_DATA:   if (r_remaining == 16'd1) w_state_nxt = ST_IDLE;
        ST_DROP:   if (r_remaining == 16'd1) w_state_nxt = ST_IDLE;
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_push     = 1'b0;
    w_last     = 1'b0;
    w_store    = 1'b0;
    w_drop_inc = 1'b0;
    w_lane_nxt = r_lane;
    w_rem_nxt  = r_remaining;
    if (!bus.flush_i && bus.wr_i) begin
      case (r_state)
        ST_IDLE: begin
          w_store    = 1'b1;
          w_lane_nxt = LW'(1);
        end
        ST_LENGTH: begin
          w_rem_nxt = bus.dat_i;
          if (w_fits) begin
            w_store = 1'b1;
            if (RATIO == 2 || bus.dat_i == '0) begin
              w_push     = 1'b1;
              w_last     = (bus.dat_i == '0);
              w_lane_nxt = '0;
            end else begin
              w_lane_nxt = LW'(2);
            end
          end else begin
            w_drop_inc = 1'b1;
            w_lane_nxt = '0;
          end
        end
        ST_DATA: begin
          w_store    = 1'b1;
          w_rem_nxt  = r_remaining - 16'd1;
          w_last     = (r_remaining == 16'd1);
          w_push     = w_last || (r_lane == LW'(RATIO - 1));
          w_lane_nxt = w_push ? '0 : r_lane + 1'b1;
        end
        ST_DROP: begin
          w_rem_nxt = r_remaining - 16'd1;
        end
        default: ;
      endcase
    end
  end

  // Lanes below the current one are already captured, the current lane is the
  // incoming word, lanes above are padding (only reachable on a frame's last word).
  always_comb begin
    w_word = '0;
    for (int unsigned k = 0; k < RATIO; k++) begin
      if (k < 32'(r_lane))       w_word[k*16 +: 16] = r_lanes[k];
      else if (k == 32'(r_lane)) w_word[k*16 +: 16] = bus.dat_i;
      else                       w_word[k*16 +: 16] = PAD_VALUE;
    end
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int unsigned k = 0; k < RATIO; k++) r_lanes[k] <= '0;
      r_lane       <= '0;
      r_remaining  <= '0;
      r_drop_cnt   <= '0;
      r_frame_done <= 1'b0;
    end else if (bus.flush_i) begin
      r_lane       <= '0;
      r_remaining  <= '0;
      r_drop_cnt   <= '0;
      r_frame_done <= 1'b0;
    end else begin
      if (w_store) r_lanes[r_lane] <= bus.dat_i;
      r_lane       <= w_lane_nxt;
      r_remaining  <= w_rem_nxt;
      r_frame_done <= w_push && w_last;
      if (w_drop_inc && r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  nofx2_sync_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n_i (rst_n_i),
    .flush_i (bus.flush_i),
    .wr_i    (w_push),
    .wdat_i  (w_word),
    .rd_i    (bus.rd_i),
    .rdat_o  (bus.dat_o),
    .used_o  (w_used),
    .full_o  (bus.full_o),
    .empty_o (bus.empty_o)
  );

  assign w_cnt_full       = 32'(w_used) * RATIO;
  assign bus.count_o      = (w_cnt_full > 32'h0000_FFFF) ? 16'hFFFF : w_cnt_full[15:0];
  assign bus.drop_cnt_o   = r_drop_cnt;
  assign bus.frame_done_o = r_frame_done;
endmodule

// File: tb/tb_nofx2_frame_packer.sv
// tb_nofx2_frame_packer: directed bench for two packer configurations
// (RATIO=2 and RATIO=4, both DEPTH=16) with scoreboard queues of expected FIFO words.
module tb_nofx2_frame_packer;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   done2  = 0;
  int   done4  = 0;
  logic [31:0] q2 [$];
  logic [63:0] q4 [$];

  always #5 clk = ~clk;

  nofx2_frame_packer_if #(.OUT_W(32)) if2 ();
  nofx2_frame_packer_if #(.OUT_W(64)) if4 ();

  nofx2_frame_packer #(.RATIO(2), .DEPTH(16), .PAD_VALUE(16'h0000)) dut2 (
    .clk(clk), .rst_n_i(rst_n), .bus(if2)
  );
  nofx2_frame_packer #(.RATIO(4), .DEPTH(16), .PAD_VALUE(16'h0000)) dut4 (
    .clk(clk), .rst_n_i(rst_n), .bus(if4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive at the falling edge, sample 1 time unit after the rising edge.
  task automatic drive2(input logic wr, input logic [15:0] d, input logic rd, input logic fl);
    @(negedge clk);
    if2.wr_i = wr; if2.dat_i = d; if2.rd_i = rd; if2.flush_i = fl;
    @(posedge clk); #1;
    if (if2.frame_done_o) done2++;
  endtask

  task automatic drive4(input logic wr, input logic [15:0] d, input logic rd, input logic fl);
    @(negedge clk);
    if4.wr_i = wr; if4.dat_i = d; if4.rd_i = rd; if4.flush_i = fl;
    @(posedge clk); #1;
    if (if4.frame_done_o) done4++;
  endtask

  task automatic rd2(input string tag);
    logic [31:0] e;
    drive2(1'b0, 16'h0, 1'b1, 1'b0);
    if (q2.size() == 0) begin
      n_chk++; n_fail++;
      $error("FAIL %s: observed %0h expected <scoreboard empty>", tag, if2.dat_o);
    end else begin
      e = q2.pop_front();
      chk(tag, 64'(if2.dat_o), 64'(e));
    end
  endtask

  task automatic rd4(input string tag);
    logic [63:0] e;
    drive4(1'b0, 16'h0, 1'b1, 1'b0);
    if (q4.size() == 0) begin
      n_chk++; n_fail++;
      $error("FAIL %s: observed %0h expected <scoreboard empty>", tag, if4.dat_o);
    end else begin
      e = q4.pop_front();
      chk(tag, if4.dat_o, e);
    end
  endtask

  initial begin
    if2.wr_i = 0; if2.dat_i = '0; if2.rd_i = 0; if2.flush_i = 0;
    if4.wr_i = 0; if4.dat_i = '0; if4.rd_i = 0; if4.flush_i = 0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_empty", 64'(if2.empty_o), 64'd1);
    chk("rst_full", 64'(if2.full_o), 64'd0);
    chk("rst_count", 64'(if2.count_o), 64'd0);
    chk("rst_drop", 64'(if2.drop_cnt_o), 64'd0);
    chk("rst_done", 64'(if2.frame_done_o), 64'd0);
    chk("rst_dat", 64'(if2.dat_o), 64'd0);
    @(negedge clk) rst_n = 1'b1;

    // RATIO=4, header-only frame: written at the LENGTH cycle
    drive4(1, 16'hBEEF, 0, 0);
    drive4(1, 16'h0000, 0, 0);
    q4.push_back(64'h0000_0000_0000_BEEF);
    chk("r4_len0_nonempty", 64'(if4.empty_o), 64'd0);
    chk("r4_len0_count", 64'(if4.count_o), 64'd4);
    chk("r4_len0_done", 64'(done4), 64'd1);
    drive4(1, 16'h1111, 0, 0);
    drive4(1, 16'h0003, 0, 0);
    drive4(1, 16'hAAAA, 0, 0);
    drive4(1, 16'hBBBB, 0, 0);
    drive4(1, 16'hCCCC, 0, 0);
    q4.push_back(64'hBBBB_AAAA_0003_1111);
    q4.push_back(64'h0000_0000_0000_CCCC);
    drive4(0, 16'h0, 0, 0);
    chk("r4_count3", 64'(if4.count_o), 64'd12);
    rd4("r4_rd0");
    rd4("r4_rd1");
    rd4("r4_rd2");
    drive4(0, 16'h0, 0, 0);
    chk("r4_empty", 64'(if4.empty_o), 64'd1);

    // RATIO=2 basic frame with padding
    done2 = 0;
    drive2(1, 16'hA5A5, 0, 0);
    drive2(1, 16'h0003, 0, 0);
    drive2(1, 16'h1111, 0, 0);
    drive2(1, 16'h2222, 0, 0);
    drive2(1, 16'h3333, 0, 0);
    q2.push_back(32'h0003_A5A5);
    q2.push_back(32'h2222_1111);
    q2.push_back(32'h0000_3333);
    chk("f1_count", 64'(if2.count_o), 64'd6);
    drive2(0, 16'h0, 0, 0);
    drive2(0, 16'h0, 0, 0);
    chk("f1_done_once", 64'(done2), 64'd1);
    rd2("f1_rd0");
    rd2("f1_rd1");
    rd2("f1_rd2");
    drive2(0, 16'h0, 0, 0);
    chk("f1_empty", 64'(if2.empty_o), 64'd1);
    drive2(0, 16'h0, 1, 0);
    chk("f1_rd_empty_hold", 64'(if2.dat_o), 64'h0000_3333);

    // Pre-fill 14 words (len=26)
    drive2(1, 16'h7E57, 0, 0);
    drive2(1, 16'h001A, 0, 0);
    q2.push_back(32'h001A_7E57);
    for (int i = 0; i < 26; i++) drive2(1, 16'h0100 + 16'(i), 0, 0);
    for (int i = 0; i < 13; i++)
      q2.push_back({16'h0100 + 16'(2*i+1), 16'h0100 + 16'(2*i)});
    chk("pf_count", 64'(if2.count_o), 64'd28);
    chk("pf_notfull", 64'(if2.full_o), 64'd0);

    // Dropped frame (need 3, free 2) immediately followed by an accepted one (need 2)
    done2 = 0;
    drive2(1, 16'h5555, 0, 0);
    drive2(1, 16'h0003, 0, 0);
    drive2(1, 16'hD001, 0, 0);
    drive2(1, 16'hD002, 0, 0);
    drive2(1, 16'hD003, 0, 0);
    drive2(1, 16'hC0DE, 0, 0);
    drive2(1, 16'h0002, 0, 0);
    drive2(1, 16'hAAAA, 0, 0);
    drive2(1, 16'hBBBB, 0, 0);
    q2.push_back(32'h0002_C0DE);
    q2.push_back(32'hBBBB_AAAA);
    drive2(0, 16'h0, 0, 0);
    chk("drop_cnt", 64'(if2.drop_cnt_o), 64'd1);
    chk("drop_full", 64'(if2.full_o), 64'd1);
    chk("drop_count", 64'(if2.count_o), 64'd32);
    chk("drop_done", 64'(done2), 64'd1);
    for (int i = 0; i < 16; i++) rd2($sformatf("drain_%0d", i));
    drive2(0, 16'h0, 0, 0);
    chk("drain_empty", 64'(if2.empty_o), 64'd1);

    // Flush mid-DATA with 5 words stored; flush also beats wr and rd
    drive2(1, 16'h1234, 0, 0);
    drive2(1, 16'h000C, 0, 0);
    for (int i = 0; i < 8; i++) drive2(1, 16'hE000 + 16'(i), 0, 0);
    chk("fl_pre_count", 64'(if2.count_o), 64'd10);
    drive2(1, 16'hDEAD, 1, 1);
    chk("fl_empty", 64'(if2.empty_o), 64'd1);
    chk("fl_count", 64'(if2.count_o), 64'd0);
    chk("fl_drop", 64'(if2.drop_cnt_o), 64'd0);
    chk("fl_dat_hold", 64'(if2.dat_o), 64'hBBBB_AAAA);
    drive2(1, 16'h7777, 0, 0);
    drive2(1, 16'h0000, 0, 0);
    q2.push_back(32'h0000_7777);
    rd2("fl_hdr");

    // Asynchronous reset mid-frame
    drive2(1, 16'h4444, 0, 0);
    drive2(1, 16'h0001, 0, 0);
    drive2(1, 16'h5555, 0, 0);
    drive2(1, 16'h6666, 0, 0);
    drive2(1, 16'h0040, 0, 0);
    drive2(1, 16'hF001, 0, 0);
    drive2(1, 16'hF002, 0, 0);
    chk("ar_pre_drop", 64'(if2.drop_cnt_o), 64'd1);
    chk("ar_pre_count", 64'(if2.count_o), 64'd4);
    #3;
    rst_n = 1'b0;
    if2.wr_i = 0;
    #1;
    chk("ar_empty", 64'(if2.empty_o), 64'd1);
    chk("ar_count", 64'(if2.count_o), 64'd0);
    chk("ar_drop", 64'(if2.drop_cnt_o), 64'd0);
    chk("ar_dat", 64'(if2.dat_o), 64'd0);
    chk("ar_dat4", if4.dat_o, 64'd0);
    q2.delete();
    @(negedge clk) rst_n = 1'b1;
    drive2(0, 16'h0, 1, 0);
    chk("ar_rd_empty_dat", 64'(if2.dat_o), 64'd0);
    chk("ar_rd_empty_flag", 64'(if2.empty_o), 64'd1);
    drive2(1, 16'h4242, 0, 0);
    drive2(1, 16'h0001, 0, 0);
    drive2(1, 16'h9999, 0, 0);
    q2.push_back(32'h0001_4242);
    q2.push_back(32'h0000_9999);
    rd2("ar_post0");
    rd2("ar_post1");
    drive2(0, 16'h0, 0, 0);
    chk("ar_post_empty", 64'(if2.empty_o), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/nofx2_frame_packer.md
# nofx2_frame_packer

Parametrised successor to the 16→32 event buffer. Packs 16-bit ATRI event frames (word 0 type, word 1 length = number of following words) into `OUT_W`-bit words. Stores them in an internal single-clock FIFO for the readout host. Adds frame-granular admission: a frame that cannot fit entirely is dropped whole and counted, so partial frames never reach the host. Sits between the event readout FSM and the host-side streaming interface.

## Interface
- `RATIO`, 2: input words per output word; legal values 2 and 4.
- `OUT_W`, 16*RATIO: output word width in bits; derived, do not override.
- `DEPTH`, 32768: FIFO depth in output words; power of 2, minimum 16.
- `PAD_VALUE`, 16'h0000: fill value for unused lanes of a frame's last output word.
- `clk` in 1: single clock for the whole block.
- `rst_n_i` in 1: asynchronous assert, active-low reset.
- `dat_i` in 16: frame word.
- `wr_i` in 1: `dat_i` valid this cycle.
- `flush_i` in 1: synchronous flush; aborts the current frame and empties the FIFO.
- `rd_i` in 1: read strobe. Non-FWFT.
- `dat_o` out OUT_W: read data, valid the cycle after an accepted `rd_i`.
- `empty_o` out 1: FIFO empty.
- `full_o` out 1: FIFO full.
- `count_o` out 16: stored 16-bit words (used×RATIO); saturates at 16'hFFFF.
- `drop_cnt_o` out 16: frames dropped since reset or flush; saturates at 16'hFFFF.
- `frame_done_o` out 1: one-cycle pulse when a frame's final output word is written.

## Operation
- FSM states:
  - **IDLE**: `wr_i` captures `dat_i` as header into lane 0. → LENGTH.
  - **LENGTH**: on `wr_i`, the block computes `need` = ceil((len+2)/RATIO), where len = `dat_i`, 17-bit arithmetic. It also computes `free` = DEPTH − used.
    - If `need` ≤ `free`: length goes into lane 1. If RATIO=2, or len=0, the output word is written (padded if lanes remain). Load remaining = len. → DATA, or → IDLE if len=0.
    - Otherwise: remaining = len. → DROP, or → IDLE if len=0. Increment `drop_cnt_o` in both cases.
  - **DATA**: each `wr_i` places `dat_i` into the next lane and decrements remaining.
    - A word is written when the lane index wraps, or on the last word (remaining==1), with upper lanes set to PAD_VALUE.
    - Last word → IDLE. `frame_done_o` pulses with that write.
  - **DROP**: each `wr_i` decrements remaining; nothing is written. At remaining==1 → IDLE.
- Lane order: the first word of each output word goes in bits [15:0], ascending, matching the existing 32-bit format.
- Every frame starts at lane 0; frames never share an output word.
- `wr_i` when `full_o` cannot occur by construction: the admission check reserves the whole frame.
- Read side:
  - `rd_i` with `empty_o`=0 pops a word. `dat_o` is registered and updates the next cycle.
  - `rd_i` while empty is ignored, and `dat_o` holds.
- Simultaneous read and write: used is unchanged; `full_o` and `empty_o` are unaffected.
- `flush_i` wins over `wr_i` and `rd_i` in the same cycle. It clears the FIFO pointers, lane index, remaining and `drop_cnt_o`. FSM → IDLE. The word on `dat_i` that cycle is discarded.
- Reset values: FSM IDLE, `empty_o`=1, `full_o`=0, `count_o`=0, `drop_cnt_o`=0, `frame_done_o`=0, `dat_o`=0.

## Timing
- A write into the FIFO occurs in the same cycle as the `wr_i` that completes the output word. `empty_o` deasserts and `count_o` updates the next cycle.
- Read latency is 1 cycle from `rd_i` to `dat_o`.
- `free` is taken from the registered used count.
  - The previous frame's final write has landed by the time of the next frame's LENGTH cycle, at least 2 cycles later, so no extra reservation is required.
  - A concurrent read only adds space, so the check is conservative.
- Back-to-back frames with `wr_i` held high are sustained at 1 word/cycle, including across DROP.
- Any frame with `need` > DEPTH is always dropped.

## Structure
- Package `nofx2_pkg`: FSM state enum, `ceil_div` function, `NOFX2_HDR_W`=16.
- Sub-module `nofx2_sync_fifo`:
  - Parameters: width, depth.
  - Registered non-FWFT output, `used` count output, full and empty.
  - Inferred block RAM.
- Top level contains the FSM, lane register and counters.

## Test plan
- RATIO=2, frame {A5A5, 0003, 1111, 2222, 3333}: FIFO holds 0003A5A5, 22221111, 00003333 (PAD 0). `frame_done_o` pulses once. `count_o`=6.
- RATIO=4, frame {BEEF, 0000}: a single word 0000_0000_0000_BEEF is written at the LENGTH cycle.
- DEPTH=16, RATIO=2, pre-fill 14 words, then a frame with len=3 (`need` 3): the frame is dropped and `drop_cnt_o`=1. A following frame with len=2 (`need` 2) is accepted, giving `full_o`=1.
- Two back-to-back frames with `wr_i` continuous, the first dropped and the second accepted: the second frame is written intact with no lost words.
- `flush_i` mid-DATA with the FIFO holding 5 words: next cycle `empty_o`=1, `count_o`=0, `drop_cnt_o`=0. The next word is parsed as a header.
- `rst_n_i` asserted mid-frame and asynchronously between clock edges: outputs take reset values immediately. Reads while empty leave `dat_o`=0.
